lc3b_control: RTL and testbench
===============================

Name: lc3b_control

Overview:
- Multicycle control FSM for the LC-3b mp1 datapath.
- Sequences the fetch, decode and execute phases.
- Drives every register load enable, mux select, ALU op and memory strobe.
- Consumes the decoded instruction fields from the instruction register plus branch_enable and mem_resp from the datapath/memory side.

Parameters:
- MEM_TIMEOUT, 64, cycles a memory wait state tolerates without mem_resp (used only with the optional feature; legal range 2..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  4  lc3b_opcode from the instruction register
- inst5  in  1  IR[5], immediate-mode select for ADD/AND
- inst11  in  1  IR[11], reserved (JSR/JSRR split), ignored in this revision
- branch_enable  in  1  nzp & cc match, valid in the BR state
- mem_resp  in  1  memory access complete, single-cycle pulse
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register load enables
- pcmux_sel  out  2  00 pc+2, 01 pc+(sext(offset9)<<1), 10 sr1_out
- marmux_sel  out  1  0 alu_out, 1 pc_out
- mdrmux_sel  out  1  0 alu_out, 1 mem_rdata
- alumux_sel  out  2  00 sr2_out, 01 sext(imm5), 10 sext(offset6)<<1
- storemux_sel  out  1  0 sr1 index = IR[8:6], 1 sr1 index = IR[11:9]
- regfilemux_sel  out  2  00 alu_out, 01 mdr_out, 10 pc+(sext(offset9)<<1)
- aluop  out  lc3b_aluop  alu_add / alu_and / alu_not / alu_pass
- mem_read, mem_write  out  1 each  memory strobes, held until mem_resp
- mem_byte_enable  out  2  fixed 2'b11 (word access only)
- mem_error  out  1  one-cycle timeout pulse (tied 0 unless macro defined)

Behaviour:
- Moore outputs decoded combinationally from state. In each state, every output not listed is 0 and aluop = alu_add. mem_byte_enable is always 2'b11.
- Reset:
  - Next state = S_FETCH1 and the timeout counter clears.
  - While reset is high, all load enables, mem_read, mem_write and mem_error are forced to 0.
  - Reset mid-access abandons the access; there is no completion handshake.
- Fetch sequence:
  - S_FETCH1: marmux=1, load_mar. Next S_FETCH2.
  - S_FETCH2: mem_read, mdrmux=1, load_mdr. Stay until mem_resp=1, then S_FETCH3.
  - S_FETCH3: load_ir, pcmux=00, load_pc. Next S_DECODE.
  - S_DECODE: no outputs. Branch on opcode to the execute state.
- Execute states:
  - ADD → S_ADD and AND → S_AND: alumux=01 if inst5 else 00; aluop per op; load_regfile, regfilemux=00, load_cc. Next S_FETCH1.
  - NOT → S_NOT: aluop=alu_not, load_regfile, load_cc. Next S_FETCH1.
  - BR → S_BR: if branch_enable go to S_BR_TAKEN, else S_FETCH1.
  - S_BR_TAKEN: pcmux=01, load_pc. Next S_FETCH1.
  - JMP → S_JMP: pcmux=10, load_pc. Next S_FETCH1.
  - LEA → S_LEA: regfilemux=10, load_regfile, load_cc. Next S_FETCH1.
  - LDR → S_CALC_ADDR: alumux=10, aluop=alu_add, marmux=0, load_mar. Next S_LDR1.
  - S_LDR1: mem_read, mdrmux=1, load_mdr. Wait for mem_resp, then S_LDR2.
  - S_LDR2: regfilemux=01, load_regfile, load_cc. Next S_FETCH1.
  - STR → S_CALC_ADDR (same outputs as for LDR), then S_STR1.
  - S_STR1: storemux=1, aluop=alu_pass, mdrmux=0, load_mdr. Next S_STR2.
  - S_STR2: mem_write. Wait for mem_resp, then S_FETCH1.
  - All other opcodes (reserved or unimplemented): S_DECODE → S_FETCH1; no architectural side effects.
- Memory handshake:
  - Strobe asserted from state entry; load_mdr is asserted throughout read waits.
  - The memory model samples only on the mem_resp cycle.
  - mem_resp arriving outside a wait state is ignored.
  - mem_resp in the first cycle of a wait state is legal (1-cycle access).
- Latency with 1-cycle memory:
  - ADD/AND/NOT/LEA/JMP/BR-not-taken: 5 cycles.
  - BR-taken: 6 cycles.
  - LDR/STR: 7 cycles.

Optional Feature:
- LC3B_MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to any wait state (S_FETCH2, S_LDR1, S_STR2) and increments each wait cycle without mem_resp.
  - If it reaches MEM_TIMEOUT-1 without mem_resp: next state S_FETCH1, mem_error=1 for that cycle, strobes drop next cycle.
  - mem_resp in the same cycle as expiry wins: normal completion, no mem_error.
- Undefined: waits are unbounded, the counter is not instantiated, mem_error is tied 0.

Decomposition:
- lc3b_types gains a lc3b_state enum, plus typedefs lc3b_pcmux_sel, lc3b_alumux_sel and lc3b_regfilemux_sel (2 bits each) with the encodings above.
- lc3b_aluop and lc3b_opcode are reused from lc3b_types.
- One sub-module: lc3b_mem_timer, holding the timeout counter, compiled only under the macro.

Test Plan:
- Reset held 3 cycles, then release → cycle 1 shows load_mar=1, marmux_sel=1; mem_read=0 throughout reset.
- ADD R1,R2,#5 (inst5=1), 1-cycle memory → load_regfile and load_cc together in the 5th cycle, alumux_sel=01, back at FETCH1 in the 6th cycle.
- BR with branch_enable=0, then again with =1 → 5 cycles, no load_pc after FETCH3; then 6 cycles with pcmux_sel=01, load_pc in the 6th cycle.
- LDR with mem_resp delayed 3 cycles in both fetch and LDR1 → mem_read held exactly 4 cycles each time; load_regfile with regfilemux_sel=01 once.
- STR → storemux_sel=1, aluop=alu_pass in STR1; mem_write high until mem_resp; never any load_regfile.
- With LC3B_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, no mem_resp in FETCH2 → mem_error pulses in the 4th wait cycle, next state FETCH1; repeat with mem_resp on that cycle → no error.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the mp1 datapath and its control unit.
// Provides the opcode and ALU op enums, the FSM state enum, and the
// 2-bit mux-select encodings driven by lc3b_control.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  typedef enum logic [1:0] {
    pcmux_plus2   = 2'b00,  // pc + 2
    pcmux_br_off  = 2'b01,  // pc + (sext(offset9) << 1)
    pcmux_sr1     = 2'b10   // sr1_out (JMP target)
  } lc3b_pcmux_sel;

  typedef enum logic [1:0] {
    alumux_sr2     = 2'b00,  // sr2_out
    alumux_imm5    = 2'b01,  // sext(imm5)
    alumux_offset6 = 2'b10   // sext(offset6) << 1
  } lc3b_alumux_sel;

  typedef enum logic [1:0] {
    rfmux_alu      = 2'b00,  // alu_out
    rfmux_mdr      = 2'b01,  // mdr_out
    rfmux_pc_off9  = 2'b10   // pc + (sext(offset9) << 1)
  } lc3b_regfilemux_sel;

  typedef enum logic [3:0] {
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR,
    S_BR_TAKEN,
    S_JMP,
    S_LEA,
    S_CALC_ADDR,
    S_LDR1,
    S_LDR2,
    S_STR1,
    S_STR2
  } lc3b_state;

  // Only word accesses are issued by this control unit.
  localparam logic [1:0] MEM_BYTE_ENABLE_WORD = 2'b11;

  // States that hold a memory strobe and wait for mem_resp.
  function automatic logic is_wait_state(input lc3b_state s);
    return (s == S_FETCH2) || (s == S_LDR1) || (s == S_STR2);
  endfunction

endpackage

// File: rtl/lc3b_mem_timer.sv
// Memory wait-state watchdog for lc3b_control (built only when
// LC3B_MEM_TIMEOUT_EN is defined).
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   in_wait        : control FSM is in a memory wait state
//   mem_resp       : memory completion pulse
//   expired        : wait has lasted MEM_TIMEOUT cycles without mem_resp
`ifdef LC3B_MEM_TIMEOUT_EN
module lc3b_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic mem_resp,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_reg;

  // The count equals the number of completed wait cycles, so the
  // MEM_TIMEOUT-th wait cycle is the one that expires.
  assign expired = in_wait & ~mem_resp & (cnt_reg == LAST_COUNT);

  // Every exit from a wait state happens on mem_resp or expiry, so
  // clearing there guarantees a zero count on the next wait entry.
  always_ff @(posedge clk) begin
    if (reset || !in_wait || mem_resp || expired) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/lc3b_control.sv
// Multicycle control FSM for the LC-3b mp1 datapath.
// Sequences fetch / decode / execute and drives every load enable, mux
// select, ALU op and memory strobe as Moore outputs of the current state.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   opcode, inst5, inst11   : fields from the instruction register
//   branch_enable           : nzp/cc match, meaningful in S_BR
//   mem_resp                : memory completion pulse
//   load_*                  : register load enables
//   *mux_sel, aluop         : datapath steering
//   mem_read/mem_write      : strobes held until mem_resp
//   mem_byte_enable         : always 2'b11
//   mem_error               : one-cycle wait timeout pulse
// Build option: LC3B_MEM_TIMEOUT_EN enables the wait-state watchdog
// (MEM_TIMEOUT cycles, legal 2..255); otherwise waits are unbounded.
module lc3b_control
  import lc3b_types::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  lc3b_opcode         opcode,
  input  logic               inst5,
  input  logic               inst11,
  input  logic               branch_enable,
  input  logic               mem_resp,
  output logic               load_pc,
  output logic               load_ir,
  output logic               load_regfile,
  output logic               load_mar,
  output logic               load_mdr,
  output logic               load_cc,
  output lc3b_pcmux_sel      pcmux_sel,
  output logic               marmux_sel,
  output logic               mdrmux_sel,
  output lc3b_alumux_sel     alumux_sel,
  output logic               storemux_sel,
  output lc3b_regfilemux_sel regfilemux_sel,
  output lc3b_aluop          aluop,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_byte_enable,
  output logic               mem_error
);

  lc3b_state state_reg;
  logic      timeout;

  // Ungated enables/strobes; reset masks them at the ports.
  logic ld_pc, ld_ir, ld_regfile, ld_mar, ld_mdr, ld_cc, rd, wr;

  // inst11 is reserved for the JSR/JSRR split and not decoded yet.
  logic unused_bits;
  assign unused_bits = ^{inst11, MEM_TIMEOUT[0]};

`ifdef LC3B_MEM_TIMEOUT_EN
  logic expired;

  lc3b_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk     (clk),
    .reset   (reset),
    .in_wait (is_wait_state(state_reg)),
    .mem_resp(mem_resp),
    .expired (expired)
  );

  assign timeout   = expired;
  assign mem_error = expired & ~reset;
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

  // State register with next-state decode. mem_resp is only looked at
  // in wait states, so stray responses elsewhere have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH1;
    end else begin
      case (state_reg)
        S_FETCH1: state_reg <= S_FETCH2;
        S_FETCH2: begin
          if (mem_resp)     state_reg <= S_FETCH3;
          else if (timeout) state_reg <= S_FETCH1;
        end
        S_FETCH3: state_reg <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            op_add:  state_reg <= S_ADD;
            op_and:  state_reg <= S_AND;
            op_not:  state_reg <= S_NOT;
            op_br:   state_reg <= S_BR;
            op_jmp:  state_reg <= S_JMP;
            op_lea:  state_reg <= S_LEA;
            op_ldr,
            op_str:  state_reg <= S_CALC_ADDR;
            default: state_reg <= S_FETCH1;
          endcase
        end
        S_BR:        state_reg <= branch_enable ? S_BR_TAKEN : S_FETCH1;
        S_CALC_ADDR: state_reg <= (opcode == op_str) ? S_STR1 : S_LDR1;
        S_LDR1: begin
          if (mem_resp)     state_reg <= S_LDR2;
          else if (timeout) state_reg <= S_FETCH1;
        end
        S_STR1: state_reg <= S_STR2;
        S_STR2: begin
          if (mem_resp || timeout) state_reg <= S_FETCH1;
        end
        default: state_reg <= S_FETCH1;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    ld_pc          = 1'b0;
    ld_ir          = 1'b0;
    ld_regfile     = 1'b0;
    ld_mar         = 1'b0;
    ld_mdr         = 1'b0;
    ld_cc          = 1'b0;
    rd             = 1'b0;
    wr             = 1'b0;
    pcmux_sel      = pcmux_plus2;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    alumux_sel     = alumux_sr2;
    storemux_sel   = 1'b0;
    regfilemux_sel = rfmux_alu;
    aluop          = alu_add;
    case (state_reg)
      S_FETCH1: begin
        marmux_sel = 1'b1;
        ld_mar     = 1'b1;
      end
      S_FETCH2, S_LDR1: begin
        rd         = 1'b1;
        mdrmux_sel = 1'b1;
        ld_mdr     = 1'b1;
      end
      S_FETCH3: begin
        ld_ir = 1'b1;
        ld_pc = 1'b1;
      end
      S_ADD, S_AND: begin
        alumux_sel = inst5 ? alumux_imm5 : alumux_sr2;
        aluop      = (state_reg == S_AND) ? alu_and : alu_add;
        ld_regfile = 1'b1;
        ld_cc      = 1'b1;
      end
      S_NOT: begin
        aluop      = alu_not;
        ld_regfile = 1'b1;
        ld_cc      = 1'b1;
      end
      S_BR_TAKEN: begin
        pcmux_sel = pcmux_br_off;
        ld_pc     = 1'b1;
      end
      S_JMP: begin
        pcmux_sel = pcmux_sr1;
        ld_pc     = 1'b1;
      end
      S_LEA: begin
        regfilemux_sel = rfmux_pc_off9;
        ld_regfile     = 1'b1;
        ld_cc          = 1'b1;
      end
      S_CALC_ADDR: begin
        alumux_sel = alumux_offset6;
        ld_mar     = 1'b1;
      end
      S_LDR2: begin
        regfilemux_sel = rfmux_mdr;
        ld_regfile     = 1'b1;
        ld_cc          = 1'b1;
      end
      S_STR1: begin
        // Route the source register (IR[11:9]) through the ALU into MDR.
        storemux_sel = 1'b1;
        aluop        = alu_pass;
        ld_mdr       = 1'b1;
      end
      S_STR2: wr = 1'b1;
      default: ;
    endcase
  end

  assign load_pc         = ld_pc & ~reset;
  assign load_ir         = ld_ir & ~reset;
  assign load_regfile    = ld_regfile & ~reset;
  assign load_mar        = ld_mar & ~reset;
  assign load_mdr        = ld_mdr & ~reset;
  assign load_cc         = ld_cc & ~reset;
  assign mem_read        = rd & ~reset;
  assign mem_write       = wr & ~reset;
  assign mem_byte_enable = MEM_BYTE_ENABLE_WORD;

endmodule

// File: tb/tb_lc3b_control.sv
// Directed testbench for lc3b_control: walks each implemented instruction
// through its state sequence and checks the full control word every cycle.
module tb_lc3b_control;
  import lc3b_types::*;

  logic               clk = 1'b0;
  logic               reset;
  lc3b_opcode         opcode;
  logic               inst5, inst11, branch_enable, mem_resp;
  logic               load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  lc3b_pcmux_sel      pcmux_sel;
  logic               marmux_sel, mdrmux_sel, storemux_sel;
  lc3b_alumux_sel     alumux_sel;
  lc3b_regfilemux_sel regfilemux_sel;
  lc3b_aluop          aluop;
  logic               mem_read, mem_write, mem_error;
  logic [1:0]         mem_byte_enable;

  int vectors = 0;
  int miscompares = 0;

  lc3b_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .inst5(inst5), .inst11(inst11),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .alumux_sel(alumux_sel), .storemux_sel(storemux_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // Control word layout (bit 20 down to 0).
  logic [20:0] ctl;
  assign ctl = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, marmux_sel, mdrmux_sel, alumux_sel, storemux_sel,
                regfilemux_sel, aluop, mem_read, mem_write, mem_error};

  localparam logic [20:0] B_LPC  = 21'd1 << 20;
  localparam logic [20:0] B_LIR  = 21'd1 << 19;
  localparam logic [20:0] B_LRF  = 21'd1 << 18;
  localparam logic [20:0] B_LMAR = 21'd1 << 17;
  localparam logic [20:0] B_LMDR = 21'd1 << 16;
  localparam logic [20:0] B_LCC  = 21'd1 << 15;
  localparam logic [20:0] PCM_BR = 21'd1 << 13;
  localparam logic [20:0] PCM_SR = 21'd2 << 13;
  localparam logic [20:0] B_MARM = 21'd1 << 12;
  localparam logic [20:0] B_MDRM = 21'd1 << 11;
  localparam logic [20:0] ALM_I5 = 21'd1 << 9;
  localparam logic [20:0] ALM_O6 = 21'd2 << 9;
  localparam logic [20:0] B_STM  = 21'd1 << 8;
  localparam logic [20:0] RFM_MD = 21'd1 << 6;
  localparam logic [20:0] RFM_PC = 21'd2 << 6;
  localparam logic [20:0] A_AND  = 21'd1 << 3;
  localparam logic [20:0] A_NOT  = 21'd2 << 3;
  localparam logic [20:0] A_PASS = 21'd3 << 3;
  localparam logic [20:0] B_MR   = 21'd1 << 2;
  localparam logic [20:0] B_MW   = 21'd1 << 1;
  localparam logic [20:0] B_ME   = 21'd1;

  localparam logic [20:0] M_EN   = B_LPC | B_LIR | B_LRF | B_LMAR | B_LMDR | B_LCC
                                 | B_MR | B_MW | B_ME;

  localparam logic [20:0] W_F1   = B_LMAR | B_MARM;
  localparam logic [20:0] W_F2   = B_MR | B_MDRM | B_LMDR;
  localparam logic [20:0] W_F3   = B_LIR | B_LPC;
  localparam logic [20:0] W_ADDI = ALM_I5 | B_LRF | B_LCC;
  localparam logic [20:0] W_ADDR = B_LRF | B_LCC;
  localparam logic [20:0] W_ANDR = A_AND | B_LRF | B_LCC;
  localparam logic [20:0] W_NOT  = A_NOT | B_LRF | B_LCC;
  localparam logic [20:0] W_BRT  = PCM_BR | B_LPC;
  localparam logic [20:0] W_JMP  = PCM_SR | B_LPC;
  localparam logic [20:0] W_LEA  = RFM_PC | B_LRF | B_LCC;
  localparam logic [20:0] W_CALC = ALM_O6 | B_LMAR;
  localparam logic [20:0] W_LDR1 = B_MR | B_MDRM | B_LMDR;
  localparam logic [20:0] W_LDR2 = RFM_MD | B_LRF | B_LCC;
  localparam logic [20:0] W_STR1 = B_STM | A_PASS | B_LMDR;
  localparam logic [20:0] W_STR2 = B_MW;

  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_resp, check mid-cycle, advance to just past the edge.
  task automatic cyc(input string tag, input logic [20:0] exp, input logic resp);
    mem_resp = resp;
    #3;
    chk(tag, ctl, exp);
    vectors++;
    assert (mem_byte_enable === 2'b11) else begin
      miscompares++;
      $error("FAIL %s_byte_enable: observed %b expected 11", tag, mem_byte_enable);
    end
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
  endtask

  // Fetch + decode with `d` wait cycles before mem_resp in FETCH2.
  task automatic fetch(input lc3b_opcode op, input int d);
    opcode = op;
    cyc("fetch1", W_F1, 1'b0);
    repeat (d) cyc("fetch2_wait", W_F2, 1'b0);
    cyc("fetch2", W_F2, 1'b1);
    cyc("fetch3", W_F3, 1'b0);
    cyc("decode", 21'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; opcode = op_br; inst5 = 1'b0; inst11 = 1'b0;
    branch_enable = 1'b0; mem_resp = 1'b0;

    // Reset held for three cycles: no enables or strobes.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_enables", ctl & M_EN, 21'd0);
    end
    reset = 1'b0;

    // ADD R1,R2,#5 with 1-cycle memory: writeback in the 5th cycle.
    inst5 = 1'b1;
    fetch(op_add, 0);
    cyc("add_imm", W_ADDI, 1'b0);

    // AND register mode; stray mem_resp in FETCH1 and DECODE is ignored.
    inst5 = 1'b0;
    opcode = op_and;
    cyc("fetch1_stray_resp", W_F1, 1'b1);
    cyc("fetch2_not_skipped", W_F2, 1'b0);
    cyc("fetch2", W_F2, 1'b1);
    cyc("fetch3", W_F3, 1'b0);
    cyc("decode_stray_resp", 21'd0, 1'b1);
    cyc("and_reg", W_ANDR, 1'b0);

    fetch(op_not, 0);
    cyc("not", W_NOT, 1'b0);

    // BR not taken (5 cycles), then taken (6 cycles).
    branch_enable = 1'b0;
    fetch(op_br, 0);
    cyc("br_not_taken", 21'd0, 1'b0);
    branch_enable = 1'b1;
    fetch(op_br, 0);
    cyc("br_eval", 21'd0, 1'b0);
    branch_enable = 1'b0;
    cyc("br_taken", W_BRT, 1'b0);

    fetch(op_jmp, 0);
    cyc("jmp", W_JMP, 1'b0);

    fetch(op_lea, 0);
    cyc("lea", W_LEA, 1'b0);

    // LDR with 3 wait cycles in both fetch and LDR1.
    fetch(op_ldr, 3);
    cyc("ldr_calc", W_CALC, 1'b0);
    repeat (3) cyc("ldr1_wait", W_LDR1, 1'b0);
    cyc("ldr1", W_LDR1, 1'b1);
    cyc("ldr2", W_LDR2, 1'b0);

    // STR: write held until mem_resp, no regfile load.
    fetch(op_str, 0);
    cyc("str_calc", W_CALC, 1'b0);
    cyc("str1", W_STR1, 1'b0);
    repeat (2) cyc("str2_wait", W_STR2, 1'b0);
    cyc("str2", W_STR2, 1'b1);

    // Reserved opcode goes straight back to fetch.
    fetch(op_trap, 0);

    // Reset in the middle of an instruction fetch abandons it.
    opcode = op_add;
    cyc("fetch1", W_F1, 1'b0);
    cyc("fetch2_wait", W_F2, 1'b0);
    reset = 1'b1;
    #3;
    chk("reset_mid_fetch", ctl & M_EN, 21'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("fetch1_after_reset", W_F1, 1'b0);
    cyc("fetch2", W_F2, 1'b1);
    cyc("fetch3", W_F3, 1'b0);
    cyc("decode", 21'd0, 1'b0);
    cyc("add_reg", W_ADDR, 1'b0);

`ifdef LC3B_MEM_TIMEOUT_EN
    // MEM_TIMEOUT=4: fourth silent wait cycle raises mem_error.
    cyc("fetch1", W_F1, 1'b0);
    repeat (3) cyc("fetch2_wait", W_F2, 1'b0);
    cyc("fetch2_timeout", W_F2 | B_ME, 1'b0);
    cyc("fetch1_after_timeout", W_F1, 1'b0);
    // mem_resp on the expiry cycle completes normally.
    repeat (3) cyc("fetch2_wait", W_F2, 1'b0);
    cyc("fetch2_resp_at_expiry", W_F2, 1'b1);
    cyc("fetch3", W_F3, 1'b0);
    cyc("decode", 21'd0, 1'b0);
    cyc("add_reg", W_ADDR, 1'b0);
`else
    // Without the watchdog a long wait is held indefinitely.
    cyc("fetch1", W_F1, 1'b0);
    repeat (8) cyc("fetch2_long_wait", W_F2, 1'b0);
    cyc("fetch2", W_F2, 1'b1);
    cyc("fetch3", W_F3, 1'b0);
    cyc("decode", 21'd0, 1'b0);
    cyc("add_reg", W_ADDR, 1'b0);
`endif
    cyc("fetch1_final", W_F1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
